// File: rtl/jt053246_drq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jt053246_drq                                                             |
// | Draw-request FIFO and tile-drawer scheduler with line-start flush.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module jt053246_drq #(
  parameter int AW    = 3,
  parameter int GUARD = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        hs,
  input  logic        vs,
  input  logic        dr_start,
  output logic        dr_busy,
  input  logic [15:0] i_code,
  input  logic [9:0]  i_attr,
  input  logic        i_hflip,
  input  logic        i_vflip,
  input  logic [8:0]  i_hpos,
  input  logic [3:0]  i_ysub,
  input  logic [11:0] i_hzoom,
  input  logic        i_hz_keep,
  output logic        drw_start,
  input  logic        drw_busy,
  output logic        drw_abort,
  output logic [15:0] o_code,
  output logic [9:0]  o_attr,
  output logic        o_hflip,
  output logic        o_vflip,
  output logic [8:0]  o_hpos,
  output logic [3:0]  o_ysub,
  output logic [11:0] o_hzoom,
  output logic        o_hz_keep,
  output logic        lb_page,
  output logic        idle,
  output logic [7:0]  drop_cnt,
  output logic        ovf
);

  localparam int                c_DEPTH = 1 << AW;
  localparam int                c_EW    = 54;
  localparam int                c_GW    = $clog2(GUARD + 2);
  localparam logic [AW:0]       c_FULL  = (AW + 1)'(c_DEPTH);
  localparam logic [c_GW-1:0]   c_GLAST = c_GW'((GUARD > 0) ? GUARD - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_hs;
  logic                r_vs;
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [AW:0]         r_count;
  logic [c_GW-1:0]     r_gcnt;
  logic [7:0]          r_acc;
  logic [c_EW-1:0]     r_mem [c_DEPTH];

  logic                w_hs_edge;
  logic                w_vs_edge;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_push_lost;
  logic                w_pop;
  logic                w_busy_state;
  logic [AW:0]         w_count_nxt;
  logic [AW+1:0]       w_drops;
  logic [8:0]          w_acc_sum;
  logic [7:0]          w_acc_sat;
  logic [7:0]          w_acc_nxt;
  logic [c_EW-1:0]     w_wdata;
  logic [c_EW-1:0]     w_rdata;

  assign w_hs_edge    = hs & ~r_hs;
  assign w_vs_edge    = vs & ~r_vs;
  assign w_full       = (r_count == c_FULL);
  assign w_empty      = (r_count == '0);
  assign w_busy_state = (r_state != ST_IDLE);

  // hs_edge is folded in so the scanner holds its request across the flush
  assign dr_busy      = w_full | w_hs_edge;

  assign w_push      = cen & dr_start & ~w_full & ~w_hs_edge;
  assign w_push_lost = cen & dr_start &  w_full & ~w_hs_edge;
  assign w_pop       = cen & ~w_hs_edge & ~w_busy_state & ~w_empty & ~drw_busy;

  assign w_wdata = {i_code, i_attr, i_hflip, i_vflip, i_hpos, i_ysub, i_hzoom, i_hz_keep};
  assign w_rdata = r_mem[r_rptr];

  assign w_drops   = {1'b0, r_count} + {{(AW + 1){1'b0}}, w_busy_state};
  assign w_acc_sum = {1'b0, r_acc} + 9'(w_drops);
  assign w_acc_sat = w_acc_sum[8] ? 8'hFF : w_acc_sum[7:0];
  assign w_acc_nxt = w_hs_edge ? w_acc_sat : r_acc;

  always_comb begin
    w_count_nxt = r_count;
    if (w_hs_edge) begin
      w_count_nxt = '0;
    end else begin
      w_count_nxt = r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (cen) begin
      if (w_hs_edge) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop)  r_rptr <= r_rptr + AW'(1);
        r_count <= w_count_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_gcnt    <= '0;
      drw_start <= 1'b0;
      drw_abort <= 1'b0;
      lb_page   <= 1'b0;
      idle      <= 1'b1;
      {o_code, o_attr, o_hflip, o_vflip, o_hpos, o_ysub, o_hzoom, o_hz_keep} <= '0;
    end else if (cen) begin
      drw_start <= 1'b0;
      drw_abort <= 1'b0;
      if (w_hs_edge) begin
        lb_page <= ~lb_page;
        if (w_busy_state) drw_abort <= 1'b1;
        r_state <= ST_IDLE;
        idle    <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_pop) begin
              {o_code, o_attr, o_hflip, o_vflip, o_hpos, o_ysub, o_hzoom, o_hz_keep} <= w_rdata;
              drw_start <= 1'b1;
              r_gcnt    <= '0;
              r_state   <= (GUARD == 0) ? ST_WAIT : ST_GUARD;
              idle      <= 1'b0;
            end else begin
              idle <= (w_count_nxt == '0);
            end
          end
          ST_GUARD: begin
            // drw_busy may not be asserted yet right after the start pulse
            if (r_gcnt == c_GLAST) begin
              r_state <= ST_WAIT;
            end else begin
              r_gcnt <= r_gcnt + c_GW'(1);
            end
            idle <= 1'b0;
          end
          ST_WAIT: begin
            if (!drw_busy) begin
              r_state <= ST_IDLE;
              idle    <= (w_count_nxt == '0);
            end else begin
              idle <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            idle    <= (w_count_nxt == '0);
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs     <= 1'b0;
      r_vs     <= 1'b0;
      r_acc    <= '0;
      drop_cnt <= '0;
      ovf      <= 1'b0;
    end else if (cen) begin
      r_hs <= hs;
      r_vs <= vs;
      if (w_vs_edge) begin
        // a coinciding line flush still belongs to the frame being closed
        drop_cnt <= w_acc_nxt;
        r_acc    <= '0;
        ovf      <= w_push_lost;
      end else begin
        r_acc <= w_acc_nxt;
        if (w_push_lost) ovf <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
